// File: rtl/izh_param_if.sv
// Parameter-load bus between the serial frame source and the Izhikevich parameter loader.
// The master drives the serial frame; the slave returns the committed parameter set and status.
interface izh_param_if #(
  parameter int PARAM_W = 8
);
  logic               load_mode;
  logic               serial_data;
  logic [PARAM_W-1:0] param_a;
  logic [PARAM_W-1:0] param_b;
  logic [PARAM_W-1:0] param_c;
  logic [PARAM_W-1:0] param_d;
  logic               params_ready;
  logic               load_error;
  logic [2:0]         debug_state;

  modport master (
    output load_mode, serial_data,
    input  param_a, param_b, param_c, param_d, params_ready, load_error, debug_state
  );

  modport slave (
    input  load_mode, serial_data,
    output param_a, param_b, param_c, param_d, params_ready, load_error, debug_state
  );
endinterface

// File: rtl/izh_param_loader.sv
// Serial loader for the Izhikevich a/b/c/d parameters: shifts a 40-bit frame MSB first,
// verifies the trailing byte-sum checksum and commits all four parameters in one edge.
module izh_param_loader #(
  parameter int                  PARAM_W  = 8,
  parameter logic [PARAM_W-1:0]  DEF_A    = 8'h02,
  parameter logic [PARAM_W-1:0]  DEF_B    = 8'h33,
  parameter logic [PARAM_W-1:0]  DEF_C    = 8'hC1,
  parameter logic [PARAM_W-1:0]  DEF_D    = 8'h08,
  parameter bit                  CHECK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  izh_param_if.slave bus
);

  localparam int          FRAME_W  = 5 * PARAM_W;
  localparam logic [5:0]  LAST_BIT = 6'(FRAME_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [5:0]           cnt_r;
  logic [FRAME_W-1:0]   shadow_r;
  logic [PARAM_W-1:0]   param_a_r;
  logic [PARAM_W-1:0]   param_b_r;
  logic [PARAM_W-1:0]   param_c_r;
  logic [PARAM_W-1:0]   param_d_r;
  logic                 ready_r;
  logic                 error_r;
  logic                 start_s;
  logic                 shift_s;
  logic                 commit_s;
  logic                 err_set_s;
  logic                 sum_ok_s;

  // Modulo-2^PARAM_W sum of the four parameter bytes; carries out of the top bit are dropped.
  function automatic logic [PARAM_W-1:0] byte_sum(input logic [4*PARAM_W-1:0] p);
    logic [PARAM_W-1:0] acc;
    acc = p[4*PARAM_W-1:3*PARAM_W] + p[3*PARAM_W-1:2*PARAM_W];
    acc = acc + p[2*PARAM_W-1:PARAM_W];
    acc = acc + p[PARAM_W-1:0];
    return acc;
  endfunction

  assign sum_ok_s = (byte_sum(shadow_r[FRAME_W-1:PARAM_W]) == shadow_r[PARAM_W-1:0]);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode and per-edge datapath strobes.
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    shift_s      = 1'b0;
    commit_s     = 1'b0;
    err_set_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.load_mode) begin
          start_s      = 1'b1;
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bus.load_mode) begin
          shift_s = 1'b1;
          if (cnt_r == LAST_BIT) begin
            state_next_s = ST_CHECK;
          end else begin
            state_next_s = ST_SHIFT;
          end
        end else begin
          state_next_s = ST_ABORT;
        end
      end
      ST_CHECK: begin
        state_next_s = ST_DONE;
        if (sum_ok_s || (CHECK_EN == 1'b0)) begin
          commit_s = 1'b1;
        end else begin
          err_set_s = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.load_mode) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ABORT: begin
        err_set_s    = 1'b1;
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Bit counter and shadow shift register; a new frame discards any stale shadow contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= 6'd0;
      shadow_r <= '0;
    end else if (start_s) begin
      cnt_r    <= 6'd1;
      shadow_r <= {{(FRAME_W-1){1'b0}}, bus.serial_data};
    end else if (shift_s) begin
      cnt_r    <= cnt_r + 6'd1;
      shadow_r <= {shadow_r[FRAME_W-2:0], bus.serial_data};
    end else begin
      cnt_r    <= cnt_r;
      shadow_r <= shadow_r;
    end
  end

  // Committed parameter set; all four registers update together or not at all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      param_a_r <= DEF_A;
      param_b_r <= DEF_B;
      param_c_r <= DEF_C;
      param_d_r <= DEF_D;
    end else if (commit_s) begin
      param_a_r <= shadow_r[FRAME_W-1:4*PARAM_W];
      param_b_r <= shadow_r[4*PARAM_W-1:3*PARAM_W];
      param_c_r <= shadow_r[3*PARAM_W-1:2*PARAM_W];
      param_d_r <= shadow_r[2*PARAM_W-1:PARAM_W];
    end else begin
      param_a_r <= param_a_r;
      param_b_r <= param_b_r;
      param_c_r <= param_c_r;
      param_d_r <= param_d_r;
    end
  end

  // Status flags: ready tracks the upcoming state, error is sticky until the next frame starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r <= 1'b1;
      error_r <= 1'b0;
    end else begin
      ready_r <= (state_next_s == ST_IDLE) || (state_next_s == ST_DONE);
      if (start_s) begin
        error_r <= 1'b0;
      end else if (err_set_s) begin
        error_r <= 1'b1;
      end else begin
        error_r <= error_r;
      end
    end
  end

  assign bus.param_a      = param_a_r;
  assign bus.param_b      = param_b_r;
  assign bus.param_c      = param_c_r;
  assign bus.param_d      = param_d_r;
  assign bus.params_ready = ready_r;
  assign bus.load_error   = error_r;
  assign bus.debug_state  = state_r;

endmodule

// File: tb/tb_izh_param_loader.sv
// Randomized scoreboard bench for izh_param_loader; a checksum-enforcing and a
// checksum-ignoring instance see the same frames and are judged against a byte-level model.
module tb_izh_param_loader;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  izh_param_if bus1 ();
  izh_param_if bus2 ();

  assign bus2.load_mode   = bus1.load_mode;
  assign bus2.serial_data = bus1.serial_data;

  izh_param_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  izh_param_loader #(.CHECK_EN(1'b0)) dut_nochk (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] p1 [4];
    logic       err1;
    logic [7:0] p2 [4];
    logic       err2;
    logic [2:0] st;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] m1 [4];
  logic [7:0] m2 [4];
  logic [7:0] defs [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic check_params(input string tag, input logic [7:0] e1 [4], input logic [7:0] e2 [4]);
    chk({tag, "_a1"}, 32'(bus1.param_a), 32'(e1[0]));
    chk({tag, "_b1"}, 32'(bus1.param_b), 32'(e1[1]));
    chk({tag, "_c1"}, 32'(bus1.param_c), 32'(e1[2]));
    chk({tag, "_d1"}, 32'(bus1.param_d), 32'(e1[3]));
    chk({tag, "_a2"}, 32'(bus2.param_a), 32'(e2[0]));
    chk({tag, "_b2"}, 32'(bus2.param_b), 32'(e2[1]));
    chk({tag, "_c2"}, 32'(bus2.param_c), 32'(e2[2]));
    chk({tag, "_d2"}, 32'(bus2.param_d), 32'(e2[3]));
  endtask

  task automatic check_idle_defaults(input string tag);
    check_params(tag, defs, defs);
    chk({tag, "_ready"}, 32'(bus1.params_ready), 32'd1);
    chk({tag, "_err"},   32'(bus1.load_error),   32'd0);
    chk({tag, "_state"}, 32'(bus1.debug_state),  32'd0);
    chk({tag, "_state2"}, 32'(bus2.debug_state), 32'd0);
  endtask

  // Drive one frame; nbits < 40 drops load_mode after nbits sampled bits.
  task automatic send_frame(input logic [7:0] pa, input logic [7:0] pb, input logic [7:0] pc,
                            input logic [7:0] pd, input logic [7:0] ck,
                            input int nbits, input int hold);
    logic [39:0] fr;
    logic [7:0]  s;
    exp_t        e;
    fr = {pa, pb, pc, pd, ck};
    s  = 8'((int'(pa) + int'(pb) + int'(pc) + int'(pd)) % 256);
    @(negedge clk);
    if (nbits == 40) begin
      if (s == ck) begin
        m1 = '{pa, pb, pc, pd};
      end
      m2     = '{pa, pb, pc, pd};
      e.err1 = (s != ck);
      e.err2 = 1'b0;
      e.st   = 3'd3;
      e.cyc  = cyc + 41;
    end else begin
      e.err1 = 1'b1;
      e.err2 = 1'b1;
      e.st   = 3'd0;
      e.cyc  = cyc + nbits + 2;
    end
    e.p1 = m1;
    e.p2 = m2;
    sb.push_back(e);
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) @(negedge clk);
      bus1.load_mode   = 1'b1;
      bus1.serial_data = fr[39-i];
    end
    if (nbits == 40) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        bus1.load_mode   = 1'b1;
        bus1.serial_data = 1'($urandom);
      end
      @(negedge clk);
      if (hold > 0) begin
        chk("done_hold_state", 32'(bus1.debug_state), 32'd3);
        check_params("done_hold", m1, m2);
      end
      bus1.load_mode = 1'b0;
    end else begin
      @(negedge clk);
      bus1.load_mode = 1'b0;
    end
    @(negedge clk);
    bus1.load_mode = 1'b0;
  endtask

  task automatic send_good(input int hold);
    logic [7:0] a, b, c, d, s;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
    s = a + b + c + d;
    send_frame(a, b, c, d, s, 40, hold);
  endtask

  // Monitor: every rising params_ready ends one frame and is checked against the oldest expectation.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b1;
      end else begin
        if (bus1.params_ready && !prev) begin
          if (sb.size() == 0) begin
            chk("unexpected_ready_rise", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("latency", 32'(cyc), 32'(e.cyc));
            check_params("commit", e.p1, e.p2);
            chk("load_error1", 32'(bus1.load_error), 32'(e.err1));
            chk("load_error2", 32'(bus2.load_error), 32'(e.err2));
            chk("ready2", 32'(bus2.params_ready), 32'd1);
            chk("state_after", 32'(bus1.debug_state), 32'(e.st));
          end
        end
        prev = bus1.params_ready;
      end
    end
  end

  initial begin
    defs = '{8'h02, 8'h33, 8'hC1, 8'h08};
    m1   = defs;
    m2   = defs;
    rst_n            = 1'b0;
    bus1.load_mode   = 1'b0;
    bus1.serial_data = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_idle_defaults("reset");

    send_frame(8'h05, 8'h10, 8'hBF, 8'h02, 8'hD6, 40, 0);
    send_frame(8'h05, 8'h10, 8'hBF, 8'h02, 8'hD7, 40, 0);
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 20, 0);
    send_good(0);
    send_good(10);
    send_good(0);
    send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC, 39, 0);
    send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC, 40, 0);
    send_frame(8'h80, 8'h01, 8'h02, 8'h03, 8'h86, 1, 0);

    // Reset in the middle of a valid frame.
    begin
      logic [39:0] fr;
      fr = {8'h12, 8'h34, 8'h56, 8'h78, 8'h14};
      for (int i = 0; i < 26; i++) begin
        @(negedge clk);
        bus1.load_mode   = 1'b1;
        bus1.serial_data = fr[39-i];
      end
      #2 rst_n = 1'b0;
      #1;
      m1 = defs;
      m2 = defs;
      check_idle_defaults("async_reset");
      repeat (2) @(negedge clk);
      bus1.load_mode = 1'b0;
      rst_n          = 1'b1;
      @(negedge clk);
      check_idle_defaults("post_reset");
    end

    for (int n = 0; n < 20; n++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      if (kind <= 1) begin
        send_good(int'($urandom_range(0, 3)));
      end else if (kind == 2) begin
        logic [7:0] a, b, c, d, s;
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
        s = a + b + c + d + 8'($urandom_range(1, 255));
        send_frame(a, b, c, d, s, 40, int'($urandom_range(0, 3)));
      end else begin
        send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                   int'($urandom_range(1, 39)), 0);
      end
    end

    for (int w = 0; w < 100 && sb.size() != 0; w++) @(negedge clk);
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
